pipe_stage_reg: RTL



---
 rtl/pipe_pkg.sv | 59 +++++
 rtl/pipe_stage_reg_if.sv | 15 +
 rtl/pipe_slot.sv | 31 +++
 rtl/pipe_stage_reg.sv | 106 ++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline payload types and widths.
// Each stage-boundary payload is a packed struct. Its flat width is exported as a
// localparam so that a pipe_stage_reg instance can be sized to carry it.
package pipe_pkg;

    localparam int unsigned PIPE_CNT_W = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  alu_op;
        logic [1:0]  op1_src;
        logic [2:0]  op2_src;
        logic        pc_op1_src;
        logic [1:0]  next_pc_src;
        logic [1:0]  wb_src;
        logic        reg_we;
        logic        ram_rd;
        logic        ram_we;
        logic        stdin_re;
        logic        stdout_we;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_res;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic [1:0]  wb_src;
        logic        reg_we;
        logic        ram_rd;
        logic        ram_we;
        logic        stdin_re;
        logic        stdout_we;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_res;
        logic [31:0] mem_data;
        logic [4:0]  rd;
        logic [1:0]  wb_src;
        logic        reg_we;
    } mem_wb_t;

    localparam int unsigned IF_ID_W  = $bits(if_id_t);
    localparam int unsigned ID_EX_W  = $bits(id_ex_t);
    localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
    localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready stream with an opaque payload.
//   valid : producer offers data
//   ready : consumer accepts this cycle
//   data  : payload, WIDTH bits
// The master modport is the producer side and the slave modport is the consumer side.
interface pipe_stage_reg_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_slot.sv
// pipe_slot: a single valid+data register.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   clr        : clear valid (wins over load); data is kept
//   load       : capture d and set valid
//   d          : incoming payload
//   valid, q   : held valid bit and payload
module pipe_slot #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush and a stall counter.
// Build option: define PIPE_STAGE_SKID_EN to add a second (skid) slot. This makes
// up.ready a pure flop output and sustains full throughput under backpressure.
// Ports:
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   flush      : synchronous squash of all held entries (data kept, valids cleared)
//   up         : upstream stream (in_valid / in_ready / in_data)
//   dn         : downstream stream (out_valid / out_ready / out_data)
//   stall_clr  : synchronous clear of stall_cnt
//   stall_cnt  : saturating count of cycles with dn.valid && !dn.ready
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = PIPE_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    pipe_stage_reg_if.slave      up,
    pipe_stage_reg_if.master     dn,
    input  logic                 stall_clr,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic             main_load;
    logic             main_clr;
    logic [WIDTH-1:0] main_d;
    logic             in_fire;
    logic             out_fire;
    logic [CNT_WIDTH-1:0] stall_q;

    assign in_fire  = up.valid && up.ready;
    assign out_fire = main_valid && dn.ready;

`ifdef PIPE_STAGE_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_load;
    logic             skid_clr;

    assign up.ready = !skid_valid;

    // skid_valid implies main_valid, and no input is accepted while the skid is full.
    always_comb begin
        skid_load = in_fire && main_valid && !dn.ready;
        skid_clr  = flush || (skid_valid && dn.ready);
        main_load = (skid_valid && dn.ready) || (in_fire && (!main_valid || dn.ready));
        main_clr  = flush || (out_fire && !skid_valid && !in_fire);
        main_d    = skid_valid ? skid_data : up.data;
    end

    pipe_slot #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .clr   (skid_clr),
        .load  (skid_load),
        .d     (up.data),
        .valid (skid_valid),
        .q     (skid_data)
    );
`else
    // Combinational path from dn.ready: a drained head frees the slot in the same cycle.
    assign up.ready = !main_valid || dn.ready;

    always_comb begin
        main_load = in_fire;
        main_clr  = flush || (out_fire && !in_fire);
        main_d    = up.data;
    end
`endif

    pipe_slot #(
        .WIDTH (WIDTH)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .clr   (main_clr),
        .load  (main_load),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_data)
    );

    assign dn.valid = main_valid;
    assign dn.data  = main_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (stall_clr) begin
            stall_q <= '0;
        end else if (main_valid && !dn.ready && (stall_q != CntMax)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;

endmodule
